pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//   Owns the program counter and sequences every PC redirect in the 5-stage MIPS pipeline.
//   Each cycle it picks PC+4, the branch target from the branch-target adder, or the jump target.
//   It also honours load-use stalls, squashes wrong-path instructions via flush strobes,
//   and keeps saturating branch/stall statistics.
//   Sits between the hazard unit, the EX-stage branch compare and the IF stage.
// PARAMETERS
//   RESET_PC      32'h0000_0000  PC value loaded on reset
//   SQUASH_CYCLES 2              guard cycles after a redirect during which new redirects are ignored (>=1)
//   CNT_W         16             width of statistics counters
// PORTS
//   Clk           in   1      system clock, all state updates on rising edge
//   Reset         in   1      synchronous, active-high reset
//   Stall         in   1      load-use stall from hazard unit: hold PC
//   BranchTaken   in   1      EX-stage branch resolved taken
//   BranchTarget  in   32     branch target (PC+4 + sign-ext offset<<2) from branch-target adder
//   Jump          in   1      ID-stage j/jal decoded
//   JumpTarget    in   32     {PC+4[31:28], instr_index, 2'b00}
//   PC            out  32     current fetch address (registered)
//   PCPlus4       out  32     PC + 4, combinational, wraps mod 2^32
//   FlushIF_ID    out  1      clear IF/ID register at next edge (combinational)
//   FlushID_EX    out  1      clear ID/EX register at next edge (combinational)
//   Squashing     out  1      1 while FSM is in SQUASH
//   BranchCount   out  CNT_W  accepted taken-branch redirects, saturating
//   StallCount    out  CNT_W  cycles with PC held by Stall, saturating
// BEHAVIOUR
//   Reset (sync, wins over all inputs): PC=RESET_PC, state=RUN, squash counter=0, both counts=0.
//   Reset also forces flush outputs to 0 in the reset cycle.
//   FSM states: RUN, SQUASH.
//   RUN, per cycle, priority order:
//     1 BranchTaken=1 (accepted even if Stall=1; branch is older than the stalled instr):
//       PC<=BranchTarget, FlushIF_ID=1, FlushID_EX=1, BranchCount++ (sat).
//       Go to SQUASH with cnt=SQUASH_CYCLES-1; if SQUASH_CYCLES==1 stay in RUN.
//     2 Jump=1 and Stall=0: PC<=JumpTarget, FlushIF_ID=1, FlushID_EX=0.
//       Enter SQUASH exactly as in rule 1. Jump with Stall=1 is ignored; it is re-presented after the stall.
//     3 Stall=1: PC holds, StallCount++ (sat), no flush.
//     4 otherwise: PC<=PC+4.
//   SQUASH:
//     BranchTaken and Jump are ignored (wrong-path).
//     Stall still holds PC and still counts.
//     Otherwise PC<=PC+4. Flush outputs are 0.
//     cnt decrements each cycle; return to RUN in the cycle after cnt==0.
//   Redirect latency: target visible on PC one cycle after the request cycle.
//   Target low bits [1:0] pass through unchanged; no alignment check.
//   Arithmetic: PC+4 is 32-bit modular; 32'hFFFF_FFFC -> 32'h0000_0000.
//   Counters stick at all-ones and never wrap.
//   BranchTaken and Jump in the same RUN cycle: branch wins, jump is dropped, BranchCount++ only.
//   Reset asserted mid-SQUASH: next cycle is RUN with PC=RESET_PC; no residual squash.
// TESTING
//   1 Reset 3 cycles, then idle 4 cycles -> PC 0,4,8,12,16; flushes 0; counts 0.
//   2 At PC=0x10 assert BranchTaken, BranchTarget=0x100 for 1 cycle.
//     -> Flush pair=1 in that cycle; PC=0x100 next; then 0x104, 0x108.
//     -> Squashing=1 for 1 cycle (default params); BranchCount=1.
//   3 BranchTaken=1 + Jump=1 + Stall=1 simultaneously (targets 0x200/0x300).
//     -> PC=0x200; FlushID_EX=1; StallCount unchanged; BranchCount+1.
//   4 Jump=1 with Stall=1 for 2 cycles, then Stall=0 (JumpTarget=0x400).
//     -> PC held 2 cycles; StallCount+2; PC=0x400 after release; FlushID_EX stays 0.
//   5 Branch redirect, then BranchTaken=1 during SQUASH.
//     -> second request ignored; BranchCount incremented once.
//   6 Edge cases:
//     -> RESET_PC=32'hFFFF_FFF8 counts 0xFFFF_FFFC then 0x0.
//     -> StallCount preloaded to all-ones via long stall stays 16'hFFFF.
//     -> Reset mid-SQUASH returns to RUN with PC=RESET_PC.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Program counter owner for the 5-stage pipeline: selects PC+4, branch or jump target,
// holds on load-use stalls, drives wrong-path flush strobes and keeps saturating statistics.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          SQUASH_CYCLES = 2,
  parameter int          CNT_W         = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             FlushIF_ID,
  output logic             FlushID_EX,
  output logic             Squashing,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] StallCount,
  output logic             DebugState
);

  localparam int              SQ_W       = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
  localparam logic [SQ_W-1:0] SQ_LOAD    = SQ_W'(SQUASH_CYCLES - 1);
  localparam bit              USE_SQUASH = (SQUASH_CYCLES > 1);

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  state_t          state, stateNext;
  logic [SQ_W-1:0] sqCnt, sqCntNext;
  logic [31:0]     pcNext;
  logic            takeBranch, takeJump, holdPc;

  assign PCPlus4    = PC + 32'd4;
  assign Squashing  = (state == SQUASH);
  assign DebugState = state;

  always_comb begin
    stateNext  = state;
    sqCntNext  = sqCnt;
    pcNext     = PCPlus4;
    takeBranch = 1'b0;
    takeJump   = 1'b0;
    holdPc     = 1'b0;
    FlushIF_ID = 1'b0;
    FlushID_EX = 1'b0;
    case (state)
      RUN: begin
        // The branch is older than the stalled instruction, so it goes through even under Stall.
        if (BranchTaken) begin
          takeBranch = 1'b1;
          pcNext     = BranchTarget;
          FlushIF_ID = 1'b1;
          FlushID_EX = 1'b1;
        end else if (Jump && !Stall) begin
          takeJump   = 1'b1;
          pcNext     = JumpTarget;
          FlushIF_ID = 1'b1;
        end else if (Stall) begin
          holdPc = 1'b1;
          pcNext = PC;
        end
        if ((takeBranch || takeJump) && USE_SQUASH) begin
          stateNext = SQUASH;
          sqCntNext = SQ_LOAD;
        end
      end
      SQUASH: begin
        if (Stall) begin
          holdPc = 1'b1;
          pcNext = PC;
        end
        // Leave once the guard count reaches zero; redirect requests here are wrong-path.
        if (sqCnt <= SQ_W'(1)) begin
          stateNext = RUN;
          sqCntNext = '0;
        end else begin
          sqCntNext = sqCnt - SQ_W'(1);
        end
      end
      default: begin
        stateNext = RUN;
        sqCntNext = '0;
      end
    endcase
    if (Reset) begin
      FlushIF_ID = 1'b0;
      FlushID_EX = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= RUN;
      sqCnt       <= '0;
      PC          <= RESET_PC;
      BranchCount <= '0;
      StallCount  <= '0;
    end else begin
      state <= stateNext;
      sqCnt <= sqCntNext;
      PC    <= pcNext;
      if (takeBranch && (BranchCount != {CNT_W{1'b1}}))
        BranchCount <= BranchCount + 1'b1;
      if (holdPc && (StallCount != {CNT_W{1'b1}}))
        StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: a driver pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against one of two differently parameterised instances.
module tb_pc_redirect_ctrl;

  // Inputs are driven #1 after posedge and apply for that whole cycle. Every cycle is a
  // valid output sample; the monitor pops one expectation per falling edge while the queue is non-empty.

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;

  logic [31:0] pc1, pcp1, pc2, pcp2;
  logic        fif1, fex1, sq1, dbg1, fif2, fex2, sq2, dbg2;
  logic [15:0] bc1, sc1;
  logic [3:0]  bc2, sc2;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] pc;
    logic        fif;
    logic        fex;
    logic        sq;
    logic [15:0] bc;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_redirect_ctrl dut1 (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .PC(pc1), .PCPlus4(pcp1), .FlushIF_ID(fif1), .FlushID_EX(fex1),
    .Squashing(sq1), .BranchCount(bc1), .StallCount(sc1), .DebugState(dbg1)
  );

  pc_redirect_ctrl #(.RESET_PC(32'hFFFF_FFF8), .SQUASH_CYCLES(2), .CNT_W(4)) dut2 (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .PC(pc2), .PCPlus4(pcp2), .FlushIF_ID(fif2), .FlushID_EX(fex2),
    .Squashing(sq2), .BranchCount(bc2), .StallCount(sc2), .DebugState(dbg2)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one call = one clock cycle; sel 1/2 selects the checked instance, 0 = unchecked
  task automatic cyc(input logic [1:0] sel, input logic rst, input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt, input logic st,
                     input logic [31:0] epc, input logic efif, input logic efex, input logic esq,
                     input logic [15:0] ebc, input logic [15:0] esc);
    exp_t e;
    Reset = rst; BranchTaken = br; BranchTarget = bt; Jump = jp; JumpTarget = jt; Stall = st;
    if (sel != 2'd0) begin
      e = '{sel: sel, pc: epc, fif: efif, fex: efex, sq: esq, bc: ebc, sc: esc};
      exp_q.push_back(e);
    end
    @(posedge Clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel == 2'd1) begin
          chk("pc",        pc1,  e.pc);
          chk("pcplus4",   pcp1, e.pc + 32'd4);
          chk("flush_ifid", {31'd0, fif1}, {31'd0, e.fif});
          chk("flush_idex", {31'd0, fex1}, {31'd0, e.fex});
          chk("squashing", {31'd0, sq1},  {31'd0, e.sq});
          chk("debug_state", {31'd0, dbg1}, {31'd0, e.sq});
          chk("branch_cnt", {16'd0, bc1}, {16'd0, e.bc});
          chk("stall_cnt",  {16'd0, sc1}, {16'd0, e.sc});
        end else begin
          chk("pc2",        pc2,  e.pc);
          chk("pcplus4_2",  pcp2, e.pc + 32'd4);
          chk("flush_ifid2", {31'd0, fif2}, {31'd0, e.fif});
          chk("flush_idex2", {31'd0, fex2}, {31'd0, e.fex});
          chk("squashing2", {31'd0, sq2},  {31'd0, e.sq});
          chk("branch_cnt2", {28'd0, bc2}, {16'd0, e.bc});
          chk("stall_cnt2",  {28'd0, sc2}, {16'd0, e.sc});
        end
      end
    end
  end

  initial begin
    logic [31:0] cur, tgt;
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0; Jump = 1'b0; JumpTarget = '0;
    @(posedge Clk);
    #1;
    // reset cycles: redirect requests must not flush while Reset is high
    cyc(1, 1, 1, 32'h55, 0, 0, 0,  32'h0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 32'h77, 1,  32'h0, 0, 0, 0, 0, 0);
    // idle sequential fetch
    cyc(1, 0, 0, 0, 0, 0, 0,  32'h0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,  32'h4, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,  32'h8, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,  32'hC, 0, 0, 0, 0, 0);
    // taken branch at 0x10
    cyc(1, 0, 1, 32'h100, 0, 0, 0,  32'h10,  1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,        32'h100, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,        32'h104, 0, 0, 0, 1, 0);
    // branch + jump + stall together: branch wins, no stall counted
    cyc(1, 0, 1, 32'h200, 1, 32'h300, 1,  32'h108, 1, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,              32'h200, 0, 0, 1, 2, 0);
    // jump held off by stall for two cycles, then taken
    cyc(1, 0, 0, 0, 1, 32'h400, 1,  32'h204, 0, 0, 0, 2, 0);
    cyc(1, 0, 0, 0, 1, 32'h400, 1,  32'h204, 0, 0, 0, 2, 1);
    cyc(1, 0, 0, 0, 1, 32'h400, 0,  32'h204, 1, 0, 0, 2, 2);
    cyc(1, 0, 0, 0, 0, 0, 0,        32'h400, 0, 0, 1, 2, 2);
    // redirect requests during SQUASH are ignored
    cyc(1, 0, 1, 32'h500, 0, 0, 0,          32'h404, 1, 1, 0, 2, 2);
    cyc(1, 0, 1, 32'h600, 1, 32'h700, 0,    32'h500, 0, 0, 1, 3, 2);
    cyc(1, 0, 0, 0, 0, 0, 0,                32'h504, 0, 0, 0, 3, 2);
    // stall inside SQUASH holds PC and counts
    cyc(1, 0, 1, 32'h800, 0, 0, 0,  32'h508, 1, 1, 0, 3, 2);
    cyc(1, 0, 0, 0, 0, 0, 1,        32'h800, 0, 0, 1, 4, 2);
    cyc(1, 0, 0, 0, 0, 0, 0,        32'h800, 0, 0, 0, 4, 3);
    // reset in the middle of SQUASH
    cyc(1, 0, 1, 32'h900, 0, 0, 0,  32'h804, 1, 1, 0, 4, 3);
    cyc(1, 1, 1, 32'hA00, 0, 0, 0,  32'h900, 0, 0, 1, 5, 3);
    cyc(1, 0, 0, 0, 0, 0, 0,        32'h0,   0, 0, 0, 0, 0);
    // unaligned target passes through unchanged
    cyc(1, 0, 1, 32'h123, 0, 0, 0,  32'h4,   1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,        32'h123, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,        32'h127, 0, 0, 0, 1, 0);

    // second instance: PC wrap from RESET_PC=FFFF_FFF8 and 4-bit counter saturation
    cyc(0, 1, 0, 0, 0, 0, 0,  32'h0, 0, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0, 0, 0,  32'hFFFF_FFF8, 0, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0, 0, 0,  32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0, 0, 0,  32'h0,         0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++)
      cyc(2, 0, 0, 0, 0, 0, 1,  32'h4, 0, 0, 0, 0, (i > 15) ? 16'd15 : 16'(i));
    cyc(2, 0, 0, 0, 0, 0, 0,  32'h4, 0, 0, 0, 0, 15);
    cur = 32'h8;
    for (int i = 0; i < 17; i++) begin
      tgt = 32'h1000 + 32'(i) * 32'h20;
      cyc(2, 0, 1, tgt, 0, 0, 0,  cur, 1, 1, 0, (i > 15) ? 16'd15 : 16'(i), 15);
      cyc(2, 0, 0, 0, 0, 0, 0,    tgt, 0, 0, 1, (i + 1 > 15) ? 16'd15 : 16'(i + 1), 15);
      cur = tgt + 32'd4;
    end

    @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
